// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the E-stage multiply/divide unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU).
package md_pkg;

    // Operation codes driven by the E-stage decode
    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    // Default iteration lengths; both must stay within the 4-bit counter (1..15)
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    // Multiply-accumulate ops exist only when the feature is built in
`ifdef MD_MADD_EN
    localparam logic MD_MADD_ON = 1'b1;
`else
    localparam logic MD_MADD_ON = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for accumulate ops that are actually implemented in this build
    function automatic logic md_is_madd(input logic [3:0] op);
        md_is_madd = MD_MADD_ON &
                     ((op == MD_MADD) | (op == MD_MADDU) |
                      (op == MD_MSUB) | (op == MD_MSUBU));
    endfunction

    // True for every op that runs the multiply-class latency
    function automatic logic md_is_mult(input logic [3:0] op);
        md_is_mult = (op == MD_MULT) | (op == MD_MULTU) | md_is_madd(op);
    endfunction

    // True for ops that run the divide latency
    function automatic logic md_is_div(input logic [3:0] op);
        md_is_div = (op == MD_DIV) | (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational result generator for the multiply/divide unit.
// Works on the operands latched at accept; accumulate ops (MD_MADD_EN)
// fold in the HI/LO value present at commit.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    output logic        o_we,
    output logic [63:0] o_res
);

    logic signed [63:0] w_sa;
    logic signed [63:0] w_sb;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [63:0]        w_acc;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_b_nz;
    logic [31:0]        w_bmag_nz;
    logic [31:0]        w_sq_mag;
    logic [31:0]        w_sr_mag;
    logic [31:0]        w_sq;
    logic [31:0]        w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic               w_b_zero;

    // Full 64-bit products; sign-extended operands give the signed product in the low 64 bits
    assign w_sa     = $signed({{32{i_a[31]}}, i_a});
    assign w_sb     = $signed({{32{i_b[31]}}, i_b});
    assign w_prod_s = w_sa * w_sb;
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};
    assign w_acc    = {i_hi, i_lo};

    // Signed divide through magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_b_zero  = (i_b == 32'd0);
    assign w_a_mag   = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_b_mag   = i_b[31] ? (32'd0 - i_b) : i_b;
    assign w_b_nz    = w_b_zero ? 32'd1 : i_b;
    assign w_bmag_nz = w_b_zero ? 32'd1 : w_b_mag;
    assign w_sq_mag  = w_a_mag / w_bmag_nz;
    assign w_sr_mag  = w_a_mag % w_bmag_nz;
    assign w_sq      = (i_a[31] ^ i_b[31]) ? (32'd0 - w_sq_mag) : w_sq_mag;
    assign w_sr      = i_a[31] ? (32'd0 - w_sr_mag) : w_sr_mag;
    assign w_uq      = i_a / w_b_nz;
    assign w_ur      = i_a % w_b_nz;

    // Select the result for the latched op; divide by zero suppresses the write
    always_comb begin
        o_we  = 1'b0;
        o_res = 64'd0;
        case (i_op)
            MD_MULT: begin
                o_we  = 1'b1;
                o_res = w_prod_s;
            end
            MD_MULTU: begin
                o_we  = 1'b1;
                o_res = w_prod_u;
            end
            MD_DIV: begin
                o_we  = !w_b_zero;
                o_res = {w_sr, w_sq};
            end
            MD_DIVU: begin
                o_we  = !w_b_zero;
                o_res = {w_ur, w_uq};
            end
            MD_MADD: begin
                o_we  = MD_MADD_ON;
                o_res = w_acc + w_prod_s;
            end
            MD_MADDU: begin
                o_we  = MD_MADD_ON;
                o_res = w_acc + w_prod_u;
            end
            MD_MSUB: begin
                o_we  = MD_MADD_ON;
                o_res = w_acc - w_prod_s;
            end
            MD_MSUBU: begin
                o_we  = MD_MADD_ON;
                o_res = w_acc - w_prod_u;
            end
            default: begin
                o_we  = 1'b0;
                o_res = 64'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the architectural HI/LO.
// Fixed-latency iteration: MULT_LAT cycles for multiply-class ops,
// DIV_LAT cycles for divides; both must be 1..15 (4-bit counter).
// Optional feature macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    md_state_e   r_state;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        w_calc_we;
    logic [63:0] w_calc_res;

    md_calc u_calc (
        .i_op  (r_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .o_we  (w_calc_we),
        .o_res (w_calc_res)
    );

    // Control FSM: accept, count down, commit HI/LO on the final busy edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= MD_NONE;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (op != MD_NONE)) begin
                        if (op == MD_MTHI) begin
                            r_hi <= a;
                        end else if (op == MD_MTLO) begin
                            r_lo <= a;
                        end else if (md_is_mult(op)) begin
                            r_op    <= op;
                            r_a     <= a;
                            r_b     <= b;
                            r_cnt   <= MULT_CNT;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else if (md_is_div(op)) begin
                            r_op    <= op;
                            r_a     <= a;
                            r_b     <= b;
                            r_cnt   <= DIV_CNT;
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            // unlisted or disabled op: dropped
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (r_cnt == 4'd1) begin
                        if (w_calc_we) begin
                            r_hi <= w_calc_res[63:32];
                            r_lo <= w_calc_res[31:0];
                        end else begin
                            // divide by zero leaves HI/LO untouched
                            r_hi <= r_hi;
                        end
                        r_cnt   <= 4'd0;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: self-checking bench for md_unit with directed plan cases,
// randomized ops and an arithmetic reference model of HI/LO and latency.
module tb_md_unit;
    import md_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Reference: applies an op to HI/LO using plain 64-bit arithmetic and
    // returns its busy length (0 = single cycle, -1 = ignored).
    function automatic int model_step(input logic [3:0] f_op, input logic [31:0] f_a,
                                      input logic [31:0] f_b,
                                      inout logic [31:0] f_hi, inout logic [31:0] f_lo);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     acc;
        sa  = longint'($signed(f_a));
        sb  = longint'($signed(f_b));
        ua  = {32'd0, f_a};
        ub  = {32'd0, f_b};
        acc = {f_hi, f_lo};
        case (f_op)
            4'd1: begin acc = sa * sb; {f_hi, f_lo} = acc; return MULT_LAT; end
            4'd2: begin acc = ua * ub; {f_hi, f_lo} = acc; return MULT_LAT; end
            4'd3: begin
                if (f_b != 32'd0) begin
                    q = sa / sb; r = sa % sb;
                    f_lo = q[31:0]; f_hi = r[31:0];
                end
                return DIV_LAT;
            end
            4'd4: begin
                if (f_b != 32'd0) begin
                    f_lo = 32'(ua / ub); f_hi = 32'(ua % ub);
                end
                return DIV_LAT;
            end
            4'd5: begin f_hi = f_a; return 0; end
            4'd6: begin f_lo = f_a; return 0; end
`ifdef MD_MADD_EN
            4'd7:  begin acc = acc + 64'(sa * sb); {f_hi, f_lo} = acc; return MULT_LAT; end
            4'd8:  begin acc = acc + 64'(ua * ub); {f_hi, f_lo} = acc; return MULT_LAT; end
            4'd9:  begin acc = acc - 64'(sa * sb); {f_hi, f_lo} = acc; return MULT_LAT; end
            4'd10: begin acc = acc - 64'(ua * ub); {f_hi, f_lo} = acc; return MULT_LAT; end
`endif
            default: return -1;
        endcase
    endfunction

    // Issue one op at a negedge and check busy/HI/LO each cycle until it retires
    task automatic run_op(input logic [3:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        int          lat;
        logic [31:0] old_hi, old_lo;
        old_hi = m_hi;
        old_lo = m_lo;
        lat = model_step(t_op, t_a, t_b, m_hi, m_lo);
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b1 || hi !== old_hi || lo !== old_lo) begin
                n_err++;
                $display("FAIL run_cycle op=%0d cyc=%0d: got busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                         t_op, k, busy, hi, lo, old_hi, old_lo);
            end
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            n_err++;
            $display("FAIL result op=%0d a=%h b=%h: got busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                     t_op, t_a, t_b, busy, hi, lo, m_hi, m_lo);
        end
    endtask

    // Explicit plan value check on HI/LO
    task automatic expect_hilo(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo);
        n_vec++;
        if (hi !== e_hi || lo !== e_lo) begin
            n_err++;
            $display("FAIL %s: got hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, e_hi, e_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = MD_NONE; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_plan();
        run_op(MD_MULT, 32'hFFFFFFFE, 32'd3);
        expect_hilo("plan_mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op(MD_MULTU, 32'hFFFFFFFE, 32'd3);
        expect_hilo("plan_multu", 32'h00000002, 32'hFFFFFFFA);
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        expect_hilo("plan_div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(MD_DIVU, 32'd7, 32'd2);
        expect_hilo("plan_divu", 32'd1, 32'd3);
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        expect_hilo("div_overflow", 32'd0, 32'h80000000);
    endtask

    task automatic test_div_zero();
        run_op(MD_MTHI, 32'h00001234, 32'd0);
        run_op(MD_MTLO, 32'h00005678, 32'd0);
        run_op(MD_DIVU, 32'd99, 32'd0);
        expect_hilo("divu_by_zero", 32'h00001234, 32'h00005678);
        run_op(MD_DIV, 32'hFFFF0000, 32'd0);
        expect_hilo("div_by_zero", 32'h00001234, 32'h00005678);
    endtask

    task automatic test_reset_abort();
        run_op(MD_MTHI, 32'hCAFEF00D, 32'd0);
        run_op(MD_MTLO, 32'h0BADBEEF, 32'd0);
        start = 1'b1; op = MD_MULT; a = 32'd1000; b = 32'd1000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_vec++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_err++;
            $display("FAIL reset_abort: got busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                n_err++;
                $display("FAIL abort_no_commit cyc=%0d: got busy=%b hi=%h lo=%h, want 0/0/0", k, busy, hi, lo);
            end
        end
    endtask

    task automatic test_back_to_back();
        // run_op issues at the first idle negedge, so the DIV follows with no gap
        run_op(MD_MULTU, 32'h00010000, 32'h00010000);
        run_op(MD_DIV, 32'd100, 32'hFFFFFFFD);
        expect_hilo("b2b_div", 32'd1, 32'hFFFFFFDF);
        run_op(MD_MTLO, 32'h11112222, 32'd0);
        run_op(MD_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
    endtask

    task automatic test_madd();
        run_op(MD_MTHI, 32'd0, 32'd0);
        run_op(MD_MTLO, 32'hFFFFFFFF, 32'd0);
        run_op(MD_MADDU, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        expect_hilo("maddu_carry", 32'd1, 32'd0);
`else
        expect_hilo("maddu_ignored", 32'd0, 32'hFFFFFFFF);
`endif
        for (int o = 7; o <= 15; o++) begin
            run_op(4'(o), $urandom, $urandom);
        end
    endtask

    task automatic test_random();
        logic [31:0] specials [6];
        logic [31:0] ra, rb;
        specials[0] = 32'h00000000; specials[1] = 32'hFFFFFFFF; specials[2] = 32'h80000000;
        specials[3] = 32'h7FFFFFFF; specials[4] = 32'h00000001; specials[5] = 32'hFFFFFFF9;
        for (int i = 0; i < 50; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            run_op(4'($urandom_range(1, 15)), ra, rb);
        end
    endtask

    initial begin
        test_reset();
        test_plan();
        test_div_zero();
        test_reset_abort();
        test_back_to_back();
        test_madd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
